// File: rtl/seg_scan_if.sv
// Bundle of display-side signals for seg_scan: digit data/strobe/enables in, decoder/anode drives out.
interface seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] data;
    logic                    load;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [3:0]              num;
    logic [NUM_DIGITS-1:0]   an;
    logic [2:0]              slot;

    modport master (
        output data, load, digit_en,
        input  num, an, slot
    );

    modport slave (
        input  data, load, digit_en,
        output num, an, slot
    );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed common-anode 7-segment scanner with an all-off gap at the start of each slot.
// Define SEG_SCAN_ZERO_BLANK_EN to add leading-zero suppression of positions 1 and up.
module seg_scan #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input logic       clk,
    input logic       rst_n,
    seg_scan_if.slave bus
);
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

    typedef enum logic {StBlank, StOn} state_e;
    localparam state_e StReset = (BLANK_CYCLES == 0) ? StOn : StBlank;

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [CntW-1:0]         div_cnt_q, div_cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    state_e                  state_q, state_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [3:0]              num_q, num_d;
    logic [2:0]              slot_q, slot_d;
    logic                    div_wrap;
    logic                    in_blank_d;
    logic [NUM_DIGITS-1:0]   suppress;

    always_comb begin
        shadow_d  = bus.load ? bus.data : shadow_q;
        div_wrap  = (div_cnt_q == CntMax);
        div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
        idx_d     = idx_q;
        if (div_wrap) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end
    end

    // The FSM tracks the counter value it will hold after this edge, so state_q and div_cnt_q agree.
    if (BLANK_CYCLES == 0) begin : g_no_blank
        assign in_blank_d = 1'b0;
    end else begin : g_blank
        assign in_blank_d = (32'(div_cnt_d) < BLANK_CYCLES);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBlank: if (!in_blank_d) state_d = StOn;
            StOn:    if (in_blank_d)  state_d = StBlank;
            default: state_d = StReset;
        endcase
    end

`ifdef SEG_SCAN_ZERO_BLANK_EN
    // A position is suppressed when it and every position above it hold zero; position 0 never is.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        suppress   = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            zero_above  = zero_above & (shadow_q[4*i +: 4] == 4'h0);
            suppress[i] = zero_above;
        end
    end
`else
    assign suppress = '0;
`endif

    always_comb begin
        an_d = '1;
        if (state_q == StOn && bus.digit_en[idx_q] && !suppress[idx_q]) begin
            an_d[idx_q] = 1'b0;
        end
        num_d  = shadow_q[4*idx_q +: 4];
        slot_d = 3'(idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            div_cnt_q <= '0;
            idx_q     <= '0;
            state_q   <= StReset;
            an_q      <= '1;
            num_q     <= '0;
            slot_q    <= '0;
        end else begin
            shadow_q  <= shadow_d;
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            an_q      <= an_d;
            num_q     <= num_d;
            slot_q    <= slot_d;
        end
    end

    assign bus.an   = an_q;
    assign bus.num  = num_q;
    assign bus.slot = slot_q;
endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: 4 digits, 8-cycle slots, 2 blank cycles, plus a zero-blank-cycle instance.
module tb_seg_scan;
    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(ND)) bus ();
    seg_scan_if #(.NUM_DIGITS(ND)) bus0 ();

    seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit suppressed(input logic [15:0] s, input int i);
`ifdef SEG_SCAN_ZERO_BLANK_EN
        int h = -1;
        for (int j = 0; j < ND; j++) if (s[j*4 +: 4] != 4'h0) h = j;
        return (i >= 1) && (i > h);
`else
        return 1'b0;
`endif
    endfunction

    // Scoreboard: the expected outputs of each edge are derived from the edge count since reset.
    typedef struct packed {
        logic [3:0] an;
        logic [3:0] num;
        logic [2:0] slot;
    } exp_t;

    exp_t        sb_q[$];
    int          t_edges = 0;
    logic [15:0] sh_m = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            t_edges = 0;
            sh_m    = '0;
            sb_q.delete();
        end else begin
            exp_t e;
            int   dc;
            int   ix;
            bit   lit;
            dc     = t_edges % SD;
            ix     = (t_edges / SD) % ND;
            lit    = (dc >= BC) && bus.digit_en[ix] && !suppressed(sh_m, ix);
            e.an   = lit ? ~(4'b0001 << ix) : 4'hF;
            e.num  = sh_m[ix*4 +: 4];
            e.slot = 3'(ix);
            sb_q.push_back(e);
            if (bus.load) sh_m = bus.data;
            t_edges++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n && sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("scoreboard", 32'({bus.an, bus.num, bus.slot}), 32'(e));
        end
        chk("an_one_low", 32'($countones(~bus.an) <= 1), 32'd1);
        chk("an0_one_low", 32'($countones(~bus0.an) <= 1), 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end, expected finish");
        $fatal(1, "bench timeout");
    end

    // Reset, then load data/en so it is sampled on the first edge after release.
    task automatic start(input logic [15:0] d, input logic [3:0] en);
        @(negedge clk);
        rst_n = 1'b0;
        bus.load = 1'b0;
        repeat (2) @(negedge clk);
        rst_n        = 1'b1;
        bus.data     = d;
        bus.digit_en = en;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  en;
        logic [15:0] an_exp;   // nibble k = an during the lit part of slot k
        logic [15:0] num_exp;  // nibble k = num during slot k
    } vec_t;

    vec_t vecs[7];

    initial begin
        int n;
        vecs[0] = '{16'h4321, 4'hF, 16'h7BDE, 16'h4321};
        vecs[1] = '{16'h4321, 4'hA, 16'h7FDF, 16'h4321};
        vecs[2] = '{16'hABCF, 4'hF, 16'h7BDE, 16'hABCF};
`ifdef SEG_SCAN_ZERO_BLANK_EN
        vecs[3] = '{16'h0050, 4'hF, 16'hFFDE, 16'h0050};
        vecs[4] = '{16'h0000, 4'hF, 16'hFFFE, 16'h0000};
`else
        vecs[3] = '{16'h0050, 4'hF, 16'h7BDE, 16'h0050};
        vecs[4] = '{16'h0000, 4'hF, 16'h7BDE, 16'h0000};
`endif
        vecs[5] = '{16'h0000, 4'h0, 16'hFFFF, 16'h0000};
        vecs[6] = '{16'h1000, 4'h4, 16'hFBFF, 16'h1000};

        bus.data      = '0;
        bus.load      = 1'b0;
        bus.digit_en  = '0;
        bus0.data     = 16'h4321;
        bus0.load     = 1'b1;
        bus0.digit_en = 4'hF;

        repeat (2) @(negedge clk);
        chk("reset_an", 32'(bus.an), 32'hF);
        chk("reset_num", 32'(bus.num), 32'h0);
        chk("reset_slot", 32'(bus.slot), 32'h0);

        for (int v = 0; v < 7; v++) begin
            start(vecs[v].data, vecs[v].en);
            for (int t = 2; t <= 40; t++) begin
                int k;
                int dc;
                @(posedge clk);
                #1;
                k  = ((t - 1) / SD) % ND;
                dc = (t - 1) % SD;
                if (dc == 5) begin
                    chk($sformatf("vec%0d_slot%0d_an", v, k), 32'(bus.an),
                        32'(vecs[v].an_exp[k*4 +: 4]));
                    chk($sformatf("vec%0d_slot%0d_num", v, k), 32'(bus.num),
                        32'(vecs[v].num_exp[k*4 +: 4]));
                    chk($sformatf("vec%0d_slot%0d_slot", v, k), 32'(bus.slot), 32'(k));
                end else if (dc == 0) begin
                    chk($sformatf("vec%0d_slot%0d_gap_an", v, k), 32'(bus.an), 32'hF);
                    chk($sformatf("vec%0d_slot%0d_gap_num", v, k), 32'(bus.num),
                        32'(vecs[v].num_exp[k*4 +: 4]));
                end
            end
        end

        // Load landing at div_cnt=5 of slot 1: num follows two edges later, anode undisturbed.
        start(16'h4321, 4'hF);
        repeat (12) @(posedge clk);
        @(negedge clk);
        bus.data = 16'h9999;
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        chk("load_edge_num_old", 32'(bus.num), 32'h2);
        chk("load_edge_an", 32'(bus.an), 32'hD);
        @(negedge clk);
        bus.load = 1'b0;
        @(posedge clk);
        #1;
        chk("load_num_new", 32'(bus.num), 32'h9);
        chk("load_an_steady", 32'(bus.an), 32'hD);
        chk("load_slot", 32'(bus.slot), 32'h1);

        // Zero-gap instance: handoff 3 -> 0 is a single edge.
        start(16'h4321, 4'hF);
        repeat (31) @(posedge clk);
        #1;
        chk("nogap_slot3_an", 32'(bus0.an), 32'h7);
        @(posedge clk);
        #1;
        chk("nogap_wrap_an", 32'(bus0.an), 32'hE);
        chk("nogap_wrap_num", 32'(bus0.num), 32'h1);
        chk("nogap_wrap_slot", 32'(bus0.slot), 32'h0);

        // Asynchronous reset mid-slot while load pulses.
        start(16'h4321, 4'hF);
        repeat (11) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", 32'(bus.an), 32'hF);
        chk("async_rst_num", 32'(bus.num), 32'h0);
        chk("async_rst_slot", 32'(bus.slot), 32'h0);
        chk("async_rst_an0", 32'(bus0.an), 32'hF);
        @(negedge clk);
        bus.data = 16'h9999;
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_load_an", 32'(bus.an), 32'hF);
        chk("rst_load_num", 32'(bus.num), 32'h0);
        @(negedge clk);
        bus.load = 1'b0;
        rst_n    = 1'b1;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.an != 4'hF) break;
        end
        chk("first_low_cycles", 32'(n), 32'(BC + 1));
        chk("first_low_an", 32'(bus.an), 32'hE);
        chk("first_low_num", 32'(bus.num), 32'h0);

        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
